// File: rtl/mc_sync_filter_if.sv
// rtl/mc_sync_filter_if.sv - channel bundle between async pins and the synchroniser/debounce filter
interface mc_sync_filter_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] async_i;
   logic             bypass_i;
   logic [WIDTH-1:0] sync_o;
   logic [WIDTH-1:0] filt_o;
   logic [WIDTH-1:0] rise_o;
   logic [WIDTH-1:0] fall_o;
   logic             change_o;

   modport master (
      output async_i, bypass_i,
      input  sync_o, filt_o, rise_o, fall_o, change_o
   );

   modport slave (
      input  async_i, bypass_i,
      output sync_o, filt_o, rise_o, fall_o, change_o
   );
endinterface

// File: rtl/mc_sync_filter.sv
// rtl/mc_sync_filter.sv - per-channel multi-flop synchroniser, debounce filter and registered edge pulses
module mc_sync_filter #(
   parameter int               WIDTH      = 4,
   parameter int               STAGES     = 2,
   parameter int               FILTER_LEN = 4,
   parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
   input  logic              clk,
   input  logic              rstn,
   mc_sync_filter_if.slave   bus
);
   localparam int            CW       = $clog2(FILTER_LEN + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

   (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] chain [STAGES];

   logic [WIDTH-1:0]         sync;
   logic [WIDTH-1:0]         filt;
   logic [WIDTH-1:0]         filt_nxt;
   logic [WIDTH-1:0][CW-1:0] cnt;
   logic [WIDTH-1:0][CW-1:0] cnt_nxt;
   logic [WIDTH-1:0]         rise;
   logic [WIDTH-1:0]         fall;
   logic                     change;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int s = 0; s < STAGES; s++) chain[s] <= RESET_VAL;
      end else begin
         chain[0] <= bus.async_i;
         for (int s = 1; s < STAGES; s++) chain[s] <= chain[s-1];
      end
   end

   assign sync = chain[STAGES-1];

   // A channel's filtered value only moves after FILTER_LEN consecutive disagreeing samples.
   always_comb begin
      filt_nxt = filt;
      cnt_nxt  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (bus.bypass_i) begin
            filt_nxt[i] = sync[i];
         end else if (sync[i] != filt[i]) begin
            if (cnt[i] == CNT_LAST) filt_nxt[i] = sync[i];
            else                    cnt_nxt[i]  = cnt[i] + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         filt   <= RESET_VAL;
         cnt    <= '0;
         rise   <= '0;
         fall   <= '0;
         change <= 1'b0;
      end else begin
         filt   <= filt_nxt;
         cnt    <= cnt_nxt;
         rise   <= filt_nxt & ~filt;
         fall   <= ~filt_nxt & filt;
         change <= |(filt_nxt ^ filt);
      end
   end

   assign bus.sync_o   = sync;
   assign bus.filt_o   = filt;
   assign bus.rise_o   = rise;
   assign bus.fall_o   = fall;
   assign bus.change_o = change;
endmodule

// File: tb/tb_mc_sync_filter.sv
// tb/tb_mc_sync_filter.sv - scoreboard bench for mc_sync_filter, default and non-zero reset value instances
module tb_mc_sync_filter;
   localparam int W  = 4;
   localparam int FL = 4;

   logic clk = 1'b0;
   logic rstn_a, rstn_b;
   always #5 clk = ~clk;

   mc_sync_filter_if #(.WIDTH(W)) ifa ();
   mc_sync_filter_if #(.WIDTH(W)) ifb ();

   mc_sync_filter #(.WIDTH(W), .STAGES(2), .FILTER_LEN(FL), .RESET_VAL(4'b0000))
      dut_a (.clk(clk), .rstn(rstn_a), .bus(ifa));
   mc_sync_filter #(.WIDTH(W), .STAGES(2), .FILTER_LEN(FL), .RESET_VAL(4'b1010))
      dut_b (.clk(clk), .rstn(rstn_b), .bus(ifb));

   typedef struct {
      int         d;
      logic [3:0] sync, filt, rise, fall;
      logic       chg;
   } exp_t;

   exp_t       sb[$];
   int         checks = 0;
   int         errors = 0;

   logic [3:0] rv     [2] = '{4'b0000, 4'b1010};
   logic [3:0] m_c0   [2];
   logic [3:0] m_c1   [2];
   logic [3:0] m_filt [2];
   logic [3:0] m_rise [2];
   logic [3:0] m_fall [2];
   logic       m_chg  [2];
   int         m_run  [2][4];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: run length of disagreement per channel; filtered value flips at run length FL.
   task automatic model_edge(input int d, input logic [3:0] a, input logic byp, input logic rn);
      logic [3:0] s, nf;
      exp_t e;
      if (!rn) begin
         m_c0[d] = rv[d]; m_c1[d] = rv[d]; m_filt[d] = rv[d];
         m_rise[d] = '0; m_fall[d] = '0; m_chg[d] = 1'b0;
         for (int i = 0; i < 4; i++) m_run[d][i] = 0;
      end else begin
         s  = m_c1[d];
         nf = m_filt[d];
         for (int i = 0; i < 4; i++) begin
            if (byp || s[i] == m_filt[d][i]) begin
               m_run[d][i] = 0;
               nf[i] = s[i];
            end else begin
               m_run[d][i]++;
               if (m_run[d][i] >= FL) begin
                  nf[i] = s[i];
                  m_run[d][i] = 0;
               end
            end
         end
         m_rise[d] = nf & ~m_filt[d];
         m_fall[d] = m_filt[d] & ~nf;
         m_chg[d]  = (nf != m_filt[d]);
         m_filt[d] = nf;
         m_c1[d]   = m_c0[d];
         m_c0[d]   = a;
      end
      e.d = d; e.sync = m_c1[d]; e.filt = m_filt[d];
      e.rise = m_rise[d]; e.fall = m_fall[d]; e.chg = m_chg[d];
      sb.push_back(e);
   endtask

   task automatic cyc(input logic [3:0] aa, input logic ba, input logic ra,
                      input logic [3:0] ab, input logic rb);
      exp_t e;
      ifa.async_i = aa; ifa.bypass_i = ba; rstn_a = ra;
      ifb.async_i = ab; ifb.bypass_i = 1'b0; rstn_b = rb;
      model_edge(0, aa, ba, ra);
      model_edge(1, ab, 1'b0, rb);
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         if (e.d == 0) begin
            check("a_sync", ifa.sync_o, e.sync);
            check("a_filt", ifa.filt_o, e.filt);
            check("a_rise", ifa.rise_o, e.rise);
            check("a_fall", ifa.fall_o, e.fall);
            check("a_chg",  ifa.change_o, e.chg);
         end else begin
            check("b_sync", ifb.sync_o, e.sync);
            check("b_filt", ifb.filt_o, e.filt);
            check("b_rise", ifb.rise_o, e.rise);
            check("b_fall", ifb.fall_o, e.fall);
            check("b_chg",  ifb.change_o, e.chg);
         end
      end
   endtask

   initial begin
      int pulses, rise_at, fall_at;
      logic [3:0] r;
      logic       rb;

      repeat (5) cyc(4'hF, 1'b0, 1'b0, 4'hA, 1'b0);
      check("rst_filt", ifa.filt_o, 4'h0);
      check("rst_sync", ifa.sync_o, 4'h0);
      check("rst_chg",  ifa.change_o, 1'b0);

      for (int e = 1; e <= 8; e++) begin
         cyc(4'hF, 1'b0, 1'b1, 4'hA, 1'b0);
         if (e == 2) check("t1_sync_e2", ifa.sync_o, 4'hF);
         if (e == 5) check("t1_filt_e5", ifa.filt_o, 4'h0);
         if (e == 6) begin
            check("t1_filt_e6", ifa.filt_o, 4'hF);
            check("t1_rise_e6", ifa.rise_o, 4'hF);
            check("t1_chg_e6",  ifa.change_o, 1'b1);
         end
         if (e == 7) check("t1_rise_e7", ifa.rise_o, 4'h0);
      end
      repeat (10) cyc(4'h0, 1'b0, 1'b1, 4'hA, 1'b0);

      pulses = 0;
      for (int e = 0; e < 12; e++) begin
         cyc((e < 3) ? 4'h1 : 4'h0, 1'b0, 1'b1, 4'hA, 1'b0);
         pulses += int'(ifa.change_o) + int'(ifa.filt_o[0]);
      end
      check("t2_glitch", pulses, 0);

      rise_at = 0; fall_at = 0;
      for (int e = 1; e <= 20; e++) begin
         cyc((e <= 10) ? 4'h2 : 4'h0, 1'b0, 1'b1, 4'hA, 1'b0);
         if (ifa.rise_o[1]) rise_at = e;
         if (ifa.fall_o[1]) fall_at = e;
      end
      check("t3_rise_at", rise_at, 6);
      check("t3_fall_at", fall_at, 16);
      repeat (4) cyc(4'h0, 1'b0, 1'b1, 4'hA, 1'b0);

      pulses = 0;
      for (int e = 0; e < 16; e++) begin
         cyc(((e / 2) % 2) ? 4'h4 : 4'h0, 1'b1, 1'b1, 4'hA, 1'b0);
         pulses += int'(ifa.rise_o[2]) + int'(ifa.fall_o[2]);
      end
      check("t4_bypass_pulses", pulses, 6);
      repeat (8) cyc(4'h0, 1'b0, 1'b1, 4'hA, 1'b0);

      repeat (4) cyc(4'h8, 1'b0, 1'b1, 4'hA, 1'b0);
      cyc(4'h8, 1'b0, 1'b0, 4'hA, 1'b0);
      check("t5_rst_filt", ifa.filt_o, 4'h0);
      check("t5_rst_rise", ifa.rise_o, 4'h0);
      for (int e = 1; e <= 7; e++) begin
         cyc(4'h8, 1'b0, 1'b1, 4'hA, 1'b0);
         if (e == 5) check("t5_filt_e5", ifa.filt_o[3], 1'b0);
         if (e == 6) begin
            check("t5_filt_e6", ifa.filt_o[3], 1'b1);
            check("t5_rise_e6", ifa.rise_o, 4'h8);
         end
      end
      repeat (8) cyc(4'h0, 1'b0, 1'b1, 4'hA, 1'b0);

      for (int e = 0; e < 40; e++) begin
         r  = 4'($urandom);
         rb = 1'($urandom_range(0, 3) == 0);
         cyc(r, rb, 1'b1, 4'hA, 1'b0);
      end

      pulses = 0;
      for (int e = 1; e <= 8; e++) begin
         cyc(4'h0, 1'b0, 1'b1, 4'hA, 1'b1);
         if (e == 1) check("t6_filt_release", ifb.filt_o, 4'hA);
         pulses += int'(ifb.change_o) + int'(ifb.rise_o != 0) + int'(ifb.fall_o != 0);
      end
      check("t6_no_pulse", pulses, 0);
      for (int e = 1; e <= 8; e++) begin
         cyc(4'h0, 1'b0, 1'b1, 4'h5, 1'b1);
         if (e == 5) check("t6_filt_e5", ifb.filt_o, 4'hA);
         if (e == 6) begin
            check("t6_rise_e6", ifb.rise_o, 4'h5);
            check("t6_fall_e6", ifb.fall_o, 4'hA);
            check("t6_chg_e6",  ifb.change_o, 1'b1);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
